meas_scheduler: RTL

- Sequences one ring-oscillator measurement cycle: clears the pulse counter, opens a fixed gate window, latches the pulse-count and duty-cycle results, then streams them as a framed packet through a single shared UART transmitter.
- Sits between the counting / duty-cycle datapath and one `uart_send` instance, replacing free-running capture and dual-UART transmission.

---
 rtl/meas_scheduler.sv | 92 +++++++++
 1 files changed

// File: rtl/meas_scheduler.sv
// meas_scheduler: sequences clear, gate, capture and framed UART transmit of one ring-oscillator measurement
// Define MEAS_CHECKSUM_EN to append a fourth byte HEADER ^ cnt ^ dc to every frame.
module meas_scheduler #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic [7:0] cnt_in,
    input  logic [7:0] dc_in,
    output logic       meas_clear,
    output logic       meas_enable,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_seq
);
`ifdef MEAS_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, CLEAR, GATE, CAPTURE, S_HDR, S_CNT, S_DC, S_CHK} state_t;
    localparam state_t S_LAST = S_CHK;
`else
    typedef enum logic [2:0] {IDLE, CLEAR, GATE, CAPTURE, S_HDR, S_CNT, S_DC} state_t;
    localparam state_t S_LAST = S_DC;
`endif
    localparam logic [19:0] GATE_LOAD = 20'(GATE_CYCLES);
    state_t      state, state_nx;
    logic [19:0] gate_cnt;
    logic [7:0]  cnt_q, dc_q;
    logic        last_xfer;
    assign last_xfer = (state == S_LAST) && tx_ready;
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start || continuous) ? CLEAR : IDLE;
            CLEAR:   state_nx = GATE;
            GATE:    state_nx = (gate_cnt == 20'd1) ? CAPTURE : GATE;
            CAPTURE: state_nx = S_HDR;
            S_HDR:   state_nx = tx_ready ? S_CNT : S_HDR;
            S_CNT:   state_nx = tx_ready ? S_DC : S_CNT;
`ifdef MEAS_CHECKSUM_EN
            S_DC:    state_nx = tx_ready ? S_CHK : S_DC;
            S_CHK:   state_nx = tx_ready ? (continuous ? CLEAR : IDLE) : S_CHK;
`else
            S_DC:    state_nx = tx_ready ? (continuous ? CLEAR : IDLE) : S_DC;
`endif
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        meas_clear  = state == CLEAR;
        meas_enable = state == GATE;
        busy        = state != IDLE;
`ifdef MEAS_CHECKSUM_EN
        tx_valid = state inside {S_HDR, S_CNT, S_DC, S_CHK};
        tx_data  = state == S_HDR ? HEADER :
                   state == S_CNT ? cnt_q :
                   state == S_DC  ? dc_q :
                   state == S_CHK ? (HEADER ^ cnt_q ^ dc_q) : 8'h00;
`else
        tx_valid = state inside {S_HDR, S_CNT, S_DC};
        tx_data  = state == S_HDR ? HEADER :
                   state == S_CNT ? cnt_q :
                   state == S_DC  ? dc_q : 8'h00;
`endif
    end
    // Results are frozen at CAPTURE so datapath changes during transmit cannot leak into the frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            gate_cnt  <= 20'd0;
            cnt_q     <= 8'h00;
            dc_q      <= 8'h00;
            done      <= 1'b0;
            frame_seq <= 8'h00;
        end else begin
            gate_cnt  <= state == CLEAR ? GATE_LOAD : state == GATE ? gate_cnt - 20'd1 : gate_cnt;
            cnt_q     <= state == CAPTURE ? cnt_in : cnt_q;
            dc_q      <= state == CAPTURE ? dc_in : dc_q;
            done      <= last_xfer;
            frame_seq <= frame_seq + {7'd0, last_xfer};
        end
    end
endmodule
